// File: rtl/sensor_frame_scheduler.sv
// Hands receiver packets to the MCU transmitter: freezes the snapshot while the MCU
// chip select is active, parks one late packet, and runs link watchdog/seq/drop counters.
//
// state   | meaning
// --------|----------------------------------------------------------
// IDLE    | cs inactive, packets published straight into the snapshot
// LOCKED  | MCU frame in progress, snapshot frozen, packets parked
// RELEASE | one-cycle window publishing the parked or incoming packet
module sensor_frame_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 2400000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pkt_strobe_i,
  input  logic               pkt_quat_valid_i,
  input  logic               pkt_gyro_valid_i,
  input  logic signed [15:0] pkt_quat_w_i,
  input  logic signed [15:0] pkt_quat_x_i,
  input  logic signed [15:0] pkt_quat_y_i,
  input  logic signed [15:0] pkt_quat_z_i,
  input  logic signed [15:0] pkt_gyro_x_i,
  input  logic signed [15:0] pkt_gyro_y_i,
  input  logic signed [15:0] pkt_gyro_z_i,
  input  logic               mcu_cs_n_i,
  output logic               snap_quat_valid_o,
  output logic               snap_gyro_valid_o,
  output logic signed [15:0] snap_quat_w_o,
  output logic signed [15:0] snap_quat_x_o,
  output logic signed [15:0] snap_quat_y_o,
  output logic signed [15:0] snap_quat_z_o,
  output logic signed [15:0] snap_gyro_x_o,
  output logic signed [15:0] snap_gyro_y_o,
  output logic signed [15:0] snap_gyro_z_o,
  output logic [7:0]         snap_seq_o,
  output logic               snap_stale_o,
  output logic               link_timeout_o,
  output logic [7:0]         dropped_count_o,
  output logic               frame_locked_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_RELEASE} state_t;

  typedef struct packed {
    logic        quat_valid;
    logic        gyro_valid;
    logic [15:0] qw;
    logic [15:0] qx;
    logic [15:0] qy;
    logic [15:0] qz;
    logic [15:0] gx;
    logic [15:0] gy;
    logic [15:0] gz;
  } pkt_t;

  state_t           state_q, state_d;
  logic             cs_meta_q, cs_s_q;
  pkt_t             pkt_in;
  pkt_t             snap_q, snap_d;
  pkt_t             pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [7:0]       seq_q, seq_d;
  logic             stale_q, stale_d;
  logic [7:0]       dropped_q, dropped_d;
  logic [CNT_W-1:0] wdt_q, wdt_d;
  logic             timeout_q, timeout_d;

  logic lock_ctx, acc_strobe, acc_pend, park, drop;

  assign pkt_in = {pkt_quat_valid_i, pkt_gyro_valid_i,
                   pkt_quat_w_i, pkt_quat_x_i, pkt_quat_y_i, pkt_quat_z_i,
                   pkt_gyro_x_i, pkt_gyro_y_i, pkt_gyro_z_i};

  // The cycle in which IDLE sees cs go active already behaves like LOCKED.
  assign lock_ctx   = (state_q == ST_LOCKED) || ((state_q == ST_IDLE) && !cs_s_q);
  assign acc_strobe = pkt_strobe_i &&
                      (((state_q == ST_IDLE) && cs_s_q) || (state_q == ST_RELEASE));
  assign acc_pend   = (state_q == ST_RELEASE) && !pkt_strobe_i && pend_full_q;
  assign park       = pkt_strobe_i && lock_ctx;
  assign drop       = pend_full_q && pkt_strobe_i && (park || (state_q == ST_RELEASE));

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    seq_d       = seq_q;
    stale_d     = stale_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    dropped_d   = dropped_q;
    wdt_d       = wdt_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      ST_IDLE:    if (!cs_s_q) state_d = ST_LOCKED;
      ST_LOCKED:  if (cs_s_q)  state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (acc_strobe || acc_pend) begin
      snap_d  = acc_strobe ? pkt_in : pend_q;
      seq_d   = seq_q + 8'd1;
      stale_d = 1'b0;
    end else if (timeout_q && (state_q != ST_LOCKED)) begin
      snap_d.quat_valid = 1'b0;
      snap_d.gyro_valid = 1'b0;
      stale_d           = 1'b1;
    end

    if (park) begin
      pend_d      = pkt_in;
      pend_full_d = 1'b1;
    end
    if (state_q == ST_RELEASE) pend_full_d = 1'b0;

    if (drop && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;

    // Strobe beats the threshold in the same cycle; counter parks at the last value.
    if (pkt_strobe_i) begin
      wdt_d     = '0;
      timeout_d = 1'b0;
    end else if (wdt_q == WDT_LAST) begin
      timeout_d = 1'b1;
    end else begin
      wdt_d = wdt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cs_meta_q   <= 1'b1;
      cs_s_q      <= 1'b1;
      snap_q      <= '0;
      seq_q       <= '0;
      stale_q     <= 1'b1;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      dropped_q   <= '0;
      wdt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_meta_q   <= mcu_cs_n_i;
      cs_s_q      <= cs_meta_q;
      snap_q      <= snap_d;
      seq_q       <= seq_d;
      stale_q     <= stale_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      dropped_q   <= dropped_d;
      wdt_q       <= wdt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign snap_quat_valid_o = snap_q.quat_valid;
  assign snap_gyro_valid_o = snap_q.gyro_valid;
  assign snap_quat_w_o     = snap_q.qw;
  assign snap_quat_x_o     = snap_q.qx;
  assign snap_quat_y_o     = snap_q.qy;
  assign snap_quat_z_o     = snap_q.qz;
  assign snap_gyro_x_o     = snap_q.gx;
  assign snap_gyro_y_o     = snap_q.gy;
  assign snap_gyro_z_o     = snap_q.gz;
  assign snap_seq_o        = seq_q;
  assign snap_stale_o      = stale_q;
  assign link_timeout_o    = timeout_q;
  assign dropped_count_o   = dropped_q;
  assign frame_locked_o    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_sensor_frame_scheduler.sv
// Directed bench for sensor_frame_scheduler with a short watchdog (100 cycles).
module tb_sensor_frame_scheduler;

  logic               clk = 1'b0;
  logic               rst;
  logic               pkt_strobe;
  logic               pkt_quat_valid, pkt_gyro_valid;
  logic signed [15:0] pkt_quat_w, pkt_quat_x, pkt_quat_y, pkt_quat_z;
  logic signed [15:0] pkt_gyro_x, pkt_gyro_y, pkt_gyro_z;
  logic               mcu_cs_n;
  logic               snap_quat_valid, snap_gyro_valid;
  logic signed [15:0] snap_quat_w, snap_quat_x, snap_quat_y, snap_quat_z;
  logic signed [15:0] snap_gyro_x, snap_gyro_y, snap_gyro_z;
  logic [7:0]         snap_seq;
  logic               snap_stale, link_timeout;
  logic [7:0]         dropped_count;
  logic               frame_locked;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] seq_exp;
  int         drop_exp;

  sensor_frame_scheduler #(.TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk), .rst_i(rst), .pkt_strobe_i(pkt_strobe),
    .pkt_quat_valid_i(pkt_quat_valid), .pkt_gyro_valid_i(pkt_gyro_valid),
    .pkt_quat_w_i(pkt_quat_w), .pkt_quat_x_i(pkt_quat_x),
    .pkt_quat_y_i(pkt_quat_y), .pkt_quat_z_i(pkt_quat_z),
    .pkt_gyro_x_i(pkt_gyro_x), .pkt_gyro_y_i(pkt_gyro_y), .pkt_gyro_z_i(pkt_gyro_z),
    .mcu_cs_n_i(mcu_cs_n),
    .snap_quat_valid_o(snap_quat_valid), .snap_gyro_valid_o(snap_gyro_valid),
    .snap_quat_w_o(snap_quat_w), .snap_quat_x_o(snap_quat_x),
    .snap_quat_y_o(snap_quat_y), .snap_quat_z_o(snap_quat_z),
    .snap_gyro_x_o(snap_gyro_x), .snap_gyro_y_o(snap_gyro_y), .snap_gyro_z_o(snap_gyro_z),
    .snap_seq_o(snap_seq), .snap_stale_o(snap_stale), .link_timeout_o(link_timeout),
    .dropped_count_o(dropped_count), .frame_locked_o(frame_locked)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input logic qv, input logic gv, input logic [15:0] qw, input logic [15:0] gz);
    pkt_quat_valid = qv;
    pkt_gyro_valid = gv;
    pkt_quat_w     = qw;
    pkt_quat_x     = qw ^ 16'h0101;
    pkt_quat_y     = qw ^ 16'h0202;
    pkt_quat_z     = qw ^ 16'h0404;
    pkt_gyro_x     = gz ^ 16'h1000;
    pkt_gyro_y     = gz ^ 16'h2000;
    pkt_gyro_z     = gz;
  endtask

  task automatic strobe_once();
    pkt_strobe = 1'b1;
    step();
    pkt_strobe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    seq_exp  = 8'd0;
    drop_exp = 0;
    n_cmp++; if (snap_stale !== 1'b1) begin n_fail++; $display("FAIL reset_stale: got %0b want 1", snap_stale); end
    n_cmp++; if (snap_seq !== 8'd0) begin n_fail++; $display("FAIL reset_seq: got %0d want 0", snap_seq); end
    n_cmp++; if ({snap_quat_valid, snap_gyro_valid, link_timeout, frame_locked} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {snap_quat_valid, snap_gyro_valid, link_timeout, frame_locked}); end
    n_cmp++; if (snap_quat_w !== 16'h0000 || dropped_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_data: got qw=%h drop=%0d want 0000/0", snap_quat_w, dropped_count); end
  endtask

  task automatic test_idle_accept();
    set_pkt(1'b1, 1'b1, 16'h1234, 16'hFFFB);
    strobe_once();
    seq_exp = seq_exp + 8'd1;
    n_cmp++; if (snap_quat_w !== 16'h1234) begin n_fail++; $display("FAIL idle_qw: got %h want 1234", snap_quat_w); end
    n_cmp++; if (snap_gyro_z !== 16'hFFFB) begin n_fail++; $display("FAIL idle_gz: got %0d want -5", snap_gyro_z); end
    n_cmp++; if (snap_quat_z !== 16'h1630) begin n_fail++; $display("FAIL idle_qz: got %h want 1630", snap_quat_z); end
    n_cmp++; if (snap_seq !== seq_exp) begin n_fail++; $display("FAIL idle_seq: got %0d want %0d", snap_seq, seq_exp); end
    n_cmp++; if ({snap_stale, frame_locked, snap_quat_valid} !== 3'b001) begin
      n_fail++; $display("FAIL idle_flags: got %b want 001", {snap_stale, frame_locked, snap_quat_valid}); end
  endtask

  task automatic test_lock_pending();
    mcu_cs_n = 1'b0;
    step();
    step();
    n_cmp++; if (frame_locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %0b want 0", frame_locked); end
    step();
    n_cmp++; if (frame_locked !== 1'b1) begin n_fail++; $display("FAIL lock_lat: got %0b want 1", frame_locked); end
    set_pkt(1'b1, 1'b1, 16'hAAAA, 16'h0003);
    pkt_strobe = 1'b1;
    step();
    set_pkt(1'b1, 1'b0, 16'hBBBB, 16'h0007);
    step();
    pkt_strobe = 1'b0;
    drop_exp = drop_exp + 1;
    n_cmp++; if (snap_quat_w !== 16'h1234 || snap_seq !== seq_exp) begin
      n_fail++; $display("FAIL lock_frozen: got qw=%h seq=%0d want 1234/%0d", snap_quat_w, snap_seq, seq_exp); end
    n_cmp++; if (dropped_count !== 8'(drop_exp)) begin n_fail++; $display("FAIL lock_drop: got %0d want %0d", dropped_count, drop_exp); end
    mcu_cs_n = 1'b1;
    step();
    step();
    n_cmp++; if (frame_locked !== 1'b1 || snap_quat_w !== 16'h1234) begin
      n_fail++; $display("FAIL unlock_hold: got lock=%0b qw=%h want 1/1234", frame_locked, snap_quat_w); end
    step();
    n_cmp++; if (frame_locked !== 1'b0 || snap_quat_w !== 16'h1234) begin
      n_fail++; $display("FAIL release_cycle: got lock=%0b qw=%h want 0/1234", frame_locked, snap_quat_w); end
    step();
    seq_exp = seq_exp + 8'd1;
    n_cmp++; if (snap_quat_w !== 16'hBBBB || snap_gyro_z !== 16'h0007 || snap_gyro_valid !== 1'b0) begin
      n_fail++; $display("FAIL pend_pub: got qw=%h gz=%h gv=%0b want BBBB/0007/0", snap_quat_w, snap_gyro_z, snap_gyro_valid); end
    n_cmp++; if (snap_seq !== seq_exp) begin n_fail++; $display("FAIL pend_seq: got %0d want %0d", snap_seq, seq_exp); end
  endtask

  task automatic test_release_strobe();
    mcu_cs_n = 1'b0;
    repeat (3) step();
    set_pkt(1'b1, 1'b1, 16'hB0B0, 16'h000B);
    strobe_once();
    mcu_cs_n = 1'b1;
    repeat (3) step();
    set_pkt(1'b1, 1'b1, 16'hC0C0, 16'h000C);
    strobe_once();
    seq_exp  = seq_exp + 8'd1;
    drop_exp = drop_exp + 1;
    n_cmp++; if (snap_quat_w !== 16'hC0C0 || snap_seq !== seq_exp) begin
      n_fail++; $display("FAIL rel_strobe: got qw=%h seq=%0d want C0C0/%0d", snap_quat_w, snap_seq, seq_exp); end
    n_cmp++; if (dropped_count !== 8'(drop_exp)) begin n_fail++; $display("FAIL rel_drop: got %0d want %0d", dropped_count, drop_exp); end
    mcu_cs_n = 1'b0;
    repeat (3) step();
    mcu_cs_n = 1'b1;
    repeat (4) step();
    n_cmp++; if (snap_quat_w !== 16'hC0C0 || snap_seq !== seq_exp) begin
      n_fail++; $display("FAIL pend_cleared: got qw=%h seq=%0d want C0C0/%0d", snap_quat_w, snap_seq, seq_exp); end
  endtask

  task automatic test_timeout();
    set_pkt(1'b1, 1'b1, 16'hD00D, 16'h000D);
    strobe_once();
    seq_exp = seq_exp + 8'd1;
    repeat (99) step();
    n_cmp++; if (link_timeout !== 1'b0) begin n_fail++; $display("FAIL wdt_early: got %0b want 0", link_timeout); end
    step();
    n_cmp++; if (link_timeout !== 1'b1) begin n_fail++; $display("FAIL wdt_fire: got %0b want 1", link_timeout); end
    step();
    n_cmp++; if ({snap_quat_valid, snap_gyro_valid, snap_stale} !== 3'b001) begin
      n_fail++; $display("FAIL wdt_clear: got %b want 001", {snap_quat_valid, snap_gyro_valid, snap_stale}); end
    set_pkt(1'b1, 1'b1, 16'hE00E, 16'h000E);
    strobe_once();
    seq_exp = seq_exp + 8'd1;
    n_cmp++; if ({link_timeout, snap_quat_valid, snap_gyro_valid, snap_stale} !== 4'b0110) begin
      n_fail++; $display("FAIL wdt_recover: got %b want 0110", {link_timeout, snap_quat_valid, snap_gyro_valid, snap_stale}); end
    n_cmp++; if (snap_seq !== seq_exp || snap_quat_w !== 16'hE00E) begin
      n_fail++; $display("FAIL wdt_recover_data: got seq=%0d qw=%h want %0d/E00E", snap_seq, snap_quat_w, seq_exp); end
  endtask

  task automatic test_timeout_locked();
    set_pkt(1'b1, 1'b1, 16'hF00F, 16'h000F);
    strobe_once();
    seq_exp = seq_exp + 8'd1;
    mcu_cs_n = 1'b0;
    repeat (105) step();
    n_cmp++; if ({frame_locked, link_timeout, snap_quat_valid, snap_stale} !== 4'b1110) begin
      n_fail++; $display("FAIL wdt_locked_hold: got %b want 1110", {frame_locked, link_timeout, snap_quat_valid, snap_stale}); end
    mcu_cs_n = 1'b1;
    repeat (3) step();
    n_cmp++; if (frame_locked !== 1'b0 || snap_quat_valid !== 1'b1) begin
      n_fail++; $display("FAIL wdt_release_hold: got lock=%0b qv=%0b want 0/1", frame_locked, snap_quat_valid); end
    step();
    n_cmp++; if ({snap_quat_valid, snap_gyro_valid, snap_stale} !== 3'b001) begin
      n_fail++; $display("FAIL wdt_release_clear: got %b want 001", {snap_quat_valid, snap_gyro_valid, snap_stale}); end
    set_pkt(1'b1, 1'b1, 16'h6060, 16'h0006);
    strobe_once();
    seq_exp = seq_exp + 8'd1;
  endtask

  task automatic test_back_to_back_wrap();
    pkt_strobe = 1'b1;
    while (seq_exp != 8'hFF) begin
      set_pkt(1'b1, 1'b1, {8'h00, seq_exp}, 16'h0001);
      step();
      seq_exp = seq_exp + 8'd1;
    end
    n_cmp++; if (snap_seq !== 8'hFF) begin n_fail++; $display("FAIL seq_255: got %0d want 255", snap_seq); end
    set_pkt(1'b1, 1'b1, 16'h0100, 16'h0001);
    step();
    pkt_strobe = 1'b0;
    seq_exp = seq_exp + 8'd1;
    n_cmp++; if (snap_seq !== 8'd0 || snap_quat_w !== 16'h0100) begin
      n_fail++; $display("FAIL seq_wrap: got seq=%0d qw=%h want 0/0100", snap_seq, snap_quat_w); end
  endtask

  task automatic test_drop_saturate();
    mcu_cs_n = 1'b0;
    repeat (3) step();
    set_pkt(1'b1, 1'b1, 16'h5A5A, 16'h0002);
    pkt_strobe = 1'b1;
    repeat (10) step();
    drop_exp = drop_exp + 9;
    n_cmp++; if (dropped_count !== 8'(drop_exp)) begin n_fail++; $display("FAIL drop_count: got %0d want %0d", dropped_count, drop_exp); end
    set_pkt(1'b1, 1'b1, 16'h7777, 16'h0002);
    repeat (290) step();
    pkt_strobe = 1'b0;
    n_cmp++; if (dropped_count !== 8'd255) begin n_fail++; $display("FAIL drop_sat: got %0d want 255", dropped_count); end
    n_cmp++; if (snap_seq !== seq_exp || snap_quat_w !== 16'h0100) begin
      n_fail++; $display("FAIL drop_frozen: got seq=%0d qw=%h want %0d/0100", snap_seq, snap_quat_w, seq_exp); end
    mcu_cs_n = 1'b1;
    repeat (4) step();
    seq_exp = seq_exp + 8'd1;
    n_cmp++; if (snap_seq !== seq_exp || snap_quat_w !== 16'h7777) begin
      n_fail++; $display("FAIL drop_pub: got seq=%0d qw=%h want %0d/7777", snap_seq, snap_quat_w, seq_exp); end
  endtask

  task automatic test_reset_locked();
    mcu_cs_n = 1'b0;
    repeat (3) step();
    set_pkt(1'b1, 1'b1, 16'h9999, 16'h0009);
    strobe_once();
    rst = 1'b1;
    step();
    rst = 1'b0;
    seq_exp  = 8'd0;
    drop_exp = 0;
    n_cmp++; if ({frame_locked, snap_stale, snap_quat_valid, link_timeout} !== 4'b0100) begin
      n_fail++; $display("FAIL rst_locked_flags: got %b want 0100", {frame_locked, snap_stale, snap_quat_valid, link_timeout}); end
    n_cmp++; if (snap_seq !== 8'd0 || dropped_count !== 8'd0 || snap_quat_w !== 16'h0000) begin
      n_fail++; $display("FAIL rst_locked_vals: got seq=%0d drop=%0d qw=%h want 0/0/0000", snap_seq, dropped_count, snap_quat_w); end
    repeat (3) step();
    n_cmp++; if (frame_locked !== 1'b1) begin n_fail++; $display("FAIL rst_relock: got %0b want 1", frame_locked); end
    mcu_cs_n = 1'b1;
    repeat (4) step();
    n_cmp++; if (snap_seq !== seq_exp || snap_quat_w !== 16'h0000 || snap_stale !== 1'b1) begin
      n_fail++; $display("FAIL rst_no_publish: got seq=%0d qw=%h stale=%0b want 0/0000/1", snap_seq, snap_quat_w, snap_stale); end
  endtask

  initial begin
    rst        = 1'b1;
    pkt_strobe = 1'b0;
    mcu_cs_n   = 1'b1;
    set_pkt(1'b0, 1'b0, 16'h0000, 16'h0000);
    test_reset();
    test_idle_accept();
    test_lock_pending();
    test_release_strobe();
    test_timeout();
    test_timeout_locked();
    test_back_to_back_wrap();
    test_drop_saturate();
    test_reset_locked();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
